// File: rtl/la_vrrarb8.sv
// la_vrrarb8: 8-way round-robin arbiter producing registered one-hot mux selects.
// Optional forced release on a hold limit: define LA_VRRARB8_TIMEOUT_EN.
module la_vrrarb8 #(
  parameter     PROP    = "DEFAULT",
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [7:0] req,
  input  logic       ready,
  input  logic       last,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_reg;
  logic [7:0] gnt_reg;
  logic [2:0] gnt_id_reg;
  logic [2:0] ptr_reg;
  logic       valid_reg;

  logic       rel_done;
  logic       force_rel;
  logic       rel_any;
  logic [2:0] arb_ptr;
  logic [7:0] req_rot;
  logic [2:0] win_off;
  logic [2:0] win_id;
  logic       win_valid;
  logic [7:0] win_gnt;

  assign rel_done = (state_reg == GRANT) && ready && last;

`ifdef LA_VRRARB8_TIMEOUT_EN
  logic [15:0] cnt_reg;
  logic        timeout_reg;
  assign force_rel = (state_reg == GRANT) && !rel_done && (cnt_reg == 16'(TIMEOUT - 1));
  assign timeout   = timeout_reg;
`else
  assign force_rel = 1'b0;
  assign timeout   = 1'b0;
`endif

  assign rel_any = rel_done || force_rel;

  // On a release edge the pointer moves past the current owner before arbitrating.
  assign arb_ptr = rel_any ? (gnt_id_reg + 3'd1) : ptr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rot
      assign req_rot[gi] = req[arb_ptr + 3'(gi)];
    end
  endgenerate

  always_comb begin
    win_off   = 3'd0;
    win_valid = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_off   = 3'(i);
        win_valid = 1'b1;
      end
    end
  end

  assign win_id  = arb_ptr + win_off;
  assign win_gnt = 8'd1 << win_id;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_reg   <= IDLE;
      gnt_reg     <= 8'h00;
      gnt_id_reg  <= 3'd0;
      ptr_reg     <= 3'd0;
      valid_reg   <= 1'b0;
`ifdef LA_VRRARB8_TIMEOUT_EN
      cnt_reg     <= 16'd0;
      timeout_reg <= 1'b0;
`endif
    end else begin
`ifdef LA_VRRARB8_TIMEOUT_EN
      timeout_reg <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            state_reg  <= GRANT;
            gnt_reg    <= win_gnt;
            gnt_id_reg <= win_id;
            valid_reg  <= 1'b1;
`ifdef LA_VRRARB8_TIMEOUT_EN
            cnt_reg    <= 16'd0;
`endif
          end
        end
        GRANT: begin
          if (rel_any) begin
            ptr_reg <= gnt_id_reg + 3'd1;
`ifdef LA_VRRARB8_TIMEOUT_EN
            timeout_reg <= force_rel;
            cnt_reg     <= 16'd0;
`endif
            if (win_valid) begin
              gnt_reg    <= win_gnt;
              gnt_id_reg <= win_id;
            end else begin
              state_reg <= IDLE;
              gnt_reg   <= 8'h00;
              valid_reg <= 1'b0;
            end
          end else begin
`ifdef LA_VRRARB8_TIMEOUT_EN
            cnt_reg <= cnt_reg + 16'd1;
`endif
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= 8'h00;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign gnt    = gnt_reg;
  assign gnt_id = gnt_id_reg;
  assign valid  = valid_reg;

endmodule

// File: tb/tb_la_vrrarb8.sv
// Self-checking bench for la_vrrarb8: directed scenarios plus randomized traffic
// checked against a round-robin reference model.
module tb_la_vrrarb8;

  localparam int TMO = 4;
`ifdef LA_VRRARB8_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nreset;
  logic [7:0] req;
  logic       ready;
  logic       last;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       valid;
  logic       timeout;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  la_vrrarb8 #(.PROP("DEFAULT"), .TIMEOUT(TMO)) dut (
    .clk(clk), .nreset(nreset), .req(req), .ready(ready), .last(last),
    .gnt(gnt), .gnt_id(gnt_id), .valid(valid), .timeout(timeout)
  );

  // Reference model: who owns the bus, where the rotating priority starts,
  // how long the owner has held it, and whether the last edge was a forced release.
  int m_ptr, m_owner, m_cnt;
  bit m_busy, m_to;

  function automatic int pick(logic [7:0] r, int p);
    for (int k = 0; k < 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  function automatic logic [7:0] m_gnt();
    return m_busy ? 8'(1 << m_owner) : 8'h00;
  endfunction

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_ptr = 0; m_owner = 0; m_cnt = 0; m_busy = 0; m_to = 0;
    end else begin
      int w;
      bit done, expired;
      m_to = 0;
      if (!m_busy) begin
        w = pick(req, m_ptr);
        if (w >= 0) begin m_busy = 1; m_owner = w; m_cnt = 0; end
      end else begin
        done    = ready && last;
        expired = TO_EN && !done && (m_cnt == TMO - 1);
        if (done || expired) begin
          m_ptr = (m_owner + 1) % 8;
          m_to  = expired;
          w = pick(req, m_ptr);
          if (w >= 0) begin m_owner = w; m_cnt = 0; end
          else m_busy = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nreset = 1'b0; req = 8'h00; ready = 1'b0; last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nreset = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    nreset = 1'b0; req = 8'hFF; ready = 1'b1; last = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++; if (gnt !== 8'h00) begin n_err++; $display("FAIL reset_gnt got=%h want=00", gnt); end
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b want=0", valid); end
    n_vec++; if (gnt_id !== 3'd0) begin n_err++; $display("FAIL reset_gnt_id got=%0d want=0", gnt_id); end
    n_vec++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got=%b want=0", timeout); end
    req = 8'h00; nreset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_vec++; if (gnt !== 8'h00 || valid !== 1'b0) begin n_err++; $display("FAIL idle_no_req gnt=%h valid=%b want 00/0", gnt, valid); end
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    ready = 1'b0; last = 1'b0; req = 8'h10;
    cyc();
    n_vec++; if (gnt !== 8'h10 || gnt_id !== 3'd4 || valid !== 1'b1) begin n_err++; $display("FAIL single_grant gnt=%h id=%0d valid=%b want 10/4/1", gnt, gnt_id, valid); end
    ready = 1'b1; last = 1'b0;
    cyc();
    n_vec++; if (gnt !== 8'h10) begin n_err++; $display("FAIL single_nonlast_hold got=%h want=10", gnt); end
    last = 1'b1; req = 8'h00;
    cyc();
    n_vec++; if (gnt !== 8'h00 || valid !== 1'b0) begin n_err++; $display("FAIL single_release gnt=%h valid=%b want 00/0", gnt, valid); end
    ready = 1'b0; last = 1'b0; req = 8'h21;
    cyc();
    n_vec++; if (gnt !== 8'h20 || gnt_id !== 3'd5) begin n_err++; $display("FAIL single_ptr5 gnt=%h id=%0d want 20/5", gnt, gnt_id); end
    ready = 1'b1; last = 1'b1; req = 8'h00;
    cyc();
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL single_idle valid=%b want 0", valid); end
    $display("test_single done");
  endtask

  task automatic test_wrap();
    ready = 1'b0; last = 1'b0; req = 8'h41;
    cyc();
    n_vec++; if (gnt !== 8'h40) begin n_err++; $display("FAIL wrap_ptr6 got=%h want=40", gnt); end
    ready = 1'b1; last = 1'b1;
    cyc();
    n_vec++; if (gnt !== 8'h01 || valid !== 1'b1) begin n_err++; $display("FAIL wrap_to0 gnt=%h valid=%b want 01/1", gnt, valid); end
    req = 8'h01;
    cyc();
    n_vec++; if (gnt !== 8'h01 || valid !== 1'b1) begin n_err++; $display("FAIL wrap_regrant gnt=%h valid=%b want 01/1", gnt, valid); end
    req = 8'h00;
    cyc();
    n_vec++; if (valid !== 1'b0) begin n_err++; $display("FAIL wrap_idle valid=%b want 0", valid); end
    $display("test_wrap done");
  endtask

  task automatic test_rotation();
    int hits [8];
    logic [7:0] want;
    do_reset();
    foreach (hits[i]) hits[i] = 0;
    req = 8'hFF; ready = 1'b1; last = 1'b1;
    for (int k = 0; k < 17; k++) begin
      cyc();
      want = 8'h01 << (k % 8);
      n_vec++; if (gnt !== want || valid !== 1'b1) begin n_err++; $display("FAIL rotation_k%0d gnt=%h valid=%b want %h/1", k, gnt, valid, want); end
      if (k < 16 && valid === 1'b1) hits[gnt_id]++;
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (hits[i] !== 2) begin n_err++; $display("FAIL rotation_fair src%0d got=%0d want=2", i, hits[i]); end
    end
    req = 8'h00;
    cyc();
    $display("test_rotation done");
  endtask

  task automatic test_stall();
    ready = 1'b0; last = 1'b0; req = 8'h08;
    cyc();
    n_vec++; if (gnt !== 8'h08) begin n_err++; $display("FAIL stall_grant got=%h want=08", gnt); end
    req = 8'hF0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_vec++; if (gnt !== 8'h08 || gnt_id !== 3'd3) begin n_err++; $display("FAIL stall_hold_c%0d gnt=%h id=%0d want 08/3", i, gnt, gnt_id); end
    end
    ready = 1'b1; last = 1'b1;
    cyc();
    n_vec++; if (gnt !== 8'h10) begin n_err++; $display("FAIL stall_next got=%h want=10", gnt); end
    req = 8'h00;
    cyc();
    $display("test_stall done");
  endtask

  task automatic test_async_reset();
    ready = 1'b0; last = 1'b0; req = 8'h02;
    cyc();
    n_vec++; if (gnt === 8'h00) begin n_err++; $display("FAIL async_pre gnt=%h want nonzero", gnt); end
    nreset = 1'b0;
    #2;
    n_vec++; if (gnt !== 8'h00 || valid !== 1'b0) begin n_err++; $display("FAIL async_reset gnt=%h valid=%b want 00/0", gnt, valid); end
    cyc();
    req = 8'h00; nreset = 1'b1;
    cyc();
    $display("test_async_reset done");
  endtask

`ifdef LA_VRRARB8_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req = 8'h04;
    cyc();
    req = 8'h0C;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_vec++; if (gnt !== 8'h04 || timeout !== 1'b0) begin n_err++; $display("FAIL to_hold_c%0d gnt=%h to=%b want 04/0", i, gnt, timeout); end
    end
    cyc();
    n_vec++; if (gnt !== 8'h08 || timeout !== 1'b1) begin n_err++; $display("FAIL to_force gnt=%h to=%b want 08/1", gnt, timeout); end
    cyc();
    n_vec++; if (timeout !== 1'b0 || gnt !== 8'h08) begin n_err++; $display("FAIL to_pulse gnt=%h to=%b want 08/0", gnt, timeout); end
    req = 8'h00; ready = 1'b1; last = 1'b1;
    cyc();
    do_reset();
    req = 8'h04;
    cyc();
    req = 8'h0C;
    repeat (3) cyc();
    ready = 1'b1; last = 1'b1;
    cyc();
    n_vec++; if (gnt !== 8'h08 || timeout !== 1'b0) begin n_err++; $display("FAIL to_normal_wins gnt=%h to=%b want 08/0", gnt, timeout); end
    req = 8'h00;
    cyc();
    $display("test_timeout done");
  endtask
`endif

  task automatic test_random();
    logic [7:0] want;
    for (int c = 0; c < 400; c++) begin
      req   = 8'($urandom) & 8'($urandom);
      ready = ($urandom_range(0, 3) != 0);
      last  = ($urandom_range(0, 2) == 0);
      if (c % 50 > 40) ready = 1'b0;
      cyc();
      want = m_gnt();
      n_vec++; if (gnt !== want || valid !== m_busy) begin n_err++; $display("FAIL rand_c%0d gnt=%h valid=%b want %h/%b", c, gnt, valid, want, m_busy); end
      n_vec++; if (m_busy && gnt_id !== 3'(m_owner)) begin n_err++; $display("FAIL rand_id_c%0d got=%0d want=%0d", c, gnt_id, m_owner); end
      n_vec++; if (timeout !== m_to) begin n_err++; $display("FAIL rand_to_c%0d got=%b want=%b", c, timeout, m_to); end
      n_vec++; if ((gnt & (gnt - 8'd1)) !== 8'h00) begin n_err++; $display("FAIL rand_onehot_c%0d gnt=%h", c, gnt); end
    end
    $display("test_random done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_rotation();
`ifndef LA_VRRARB8_TIMEOUT_EN
    test_stall();
`endif
    test_async_reset();
`ifdef LA_VRRARB8_TIMEOUT_EN
    test_timeout();
`endif
    do_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/la_vrrarb8.md
Name: la_vrrarb8

Overview:
- 8-requester round-robin arbiter that generates the registered one-hot select lines for the 8-input one-hot vectorized mux (la_vmux8) directly downstream.
- Each gnt[i] drives mux input sel<i>, so the mux never sees a multi-hot or glitching select.
- Grant is held for a full multi-beat transfer, ending on ready && last.
- Fairness comes from a rotating priority pointer.

Parameters:
- PROP, "DEFAULT", cell property string; passed through, no functional effect.
- TIMEOUT, 255, maximum cycles a grant may be held; used only with LA_VRRARB8_TIMEOUT_EN; legal range 1..65535.

Ports:
- clk  input  1  clock, rising edge.
- nreset  input  1  asynchronous active-low reset.
- req  input  8  level request per source; req[i] pairs with mux in<i>.
- ready  input  1  downstream accepts the current beat.
- last  input  1  current beat is the final beat of the granted transfer.
- gnt  output  8  registered one-hot grant; gnt[i] drives sel<i>.
- gnt_id  output  3  binary index of the granted source; valid only when valid=1.
- valid  output  1  a grant is active (equals |gnt).
- timeout  output  1  one-cycle pulse on forced release (LA_VRRARB8_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Reset: asynchronous assert, synchronous deassert. Clears gnt=0, gnt_id=0, valid=0, timeout=0, ptr=0.
- Reset mid-transfer aborts the grant immediately (combinationally through the flop reset).
- State machine has two states:
  - IDLE: valid=0.
  - GRANT: valid=1 and gnt is stable.
- IDLE -> GRANT on a clock edge where req!=0.
  - Winner is the first set req bit scanning ptr, ptr+1, ... 7, 0, ... ptr-1 (mod 8).
  - gnt, gnt_id and valid are all registered. Latency is 1 cycle from req to gnt.
- GRANT holds gnt and gnt_id unchanged while !(ready && last). Non-last beats (ready=1, last=0) do not release the grant.
- Release edge (ready && last in GRANT):
  - ptr <= gnt_id+1 (mod 8, wraps 7->0).
  - On the same edge, re-arbitrate using current req with the new ptr.
  - If a winner exists, stay in GRANT with the new gnt: zero-bubble back-to-back grants.
  - If no winner, go to IDLE with gnt=0.
- The just-released source has lowest priority on the release edge. If it is the only requester, it is re-granted immediately.
- Dropping req[gnt_id] while in GRANT does not release the grant; only ready && last (or timeout) releases it. Sources must hold req until their last beat is accepted.
- ptr changes only on release, never on initial grant from IDLE.
- Invariant: gnt is always zero-hot or one-hot, never multi-hot, including the cycle immediately after reset deassertion.
- last is ignored while valid=0. ready is ignored while valid=0.

Optional Feature:
- Macro: LA_VRRARB8_TIMEOUT_EN.
- Defined:
  - A 16-bit hold counter clears on every new grant (including back-to-back grants) and increments each cycle in GRANT.
  - When the counter reaches TIMEOUT-1 without ready && last, the next edge performs a forced release: same pointer update and re-arbitration as a normal release.
  - timeout pulses high for exactly one cycle, registered with the new grant.
  - A normal release on the same edge as expiry takes precedence, and timeout stays 0.
- Undefined:
  - No counter logic.
  - timeout is a constant 0.
  - Grants are held indefinitely.

Test Plan:
- Reset/idle: hold nreset=0 with req=8'hFF -> gnt=0, valid=0. Release reset, req=8'h00 -> gnt stays 0. Assert nreset=0 mid-GRANT -> gnt=0 immediately, not waiting for clk.
- Single requester: req=8'h10 -> after 1 edge gnt=8'h10, gnt_id=4, valid=1. Two ready&last=0/1 beats (ready=1,last=0 then ready=1,last=1) -> grant held through the first, released on the second. With req dropped, the next cycle gives gnt=0, ptr=5.
- Rotation: req=8'hFF held, ready=last=1 every cycle -> gnt sequence 01,02,04,...,80,01 with no idle cycles; each source granted exactly once per 8 cycles.
- Wrap and priority: ptr=6, req=8'h41 -> gnt=8'h40. After release -> gnt=8'h01, ptr=7. Then release with req=8'h01 only -> gnt=8'h01 re-granted with no bubble.
- Hold under stall: grant source 3, ready=0 for 20 cycles with req[3] dropped and req=8'hF0 -> gnt=8'h08 is stable for all 20 cycles. On ready&last -> gnt=8'h10.
- LA_VRRARB8_TIMEOUT_EN, TIMEOUT=4: grant source 2, ready=0 -> forced release after 4 GRANT cycles, timeout=1 for exactly one cycle, next requester granted. Same test with ready&last on cycle 4 -> timeout stays 0.
